// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types and constants (receiver and future transmitter).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int unsigned C_DEFAULT_CLK_PER_BIT = 868;
  localparam int unsigned C_DATA_W              = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_ff
// Description : Multi-stage synchroniser for an asynchronous single-bit input.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_ff #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  generate
    if (STAGES == 1) begin : g_single
      always_comb sync_d = d;
    end else begin : g_chain
      always_comb sync_d = {sync_q[STAGES-2:0], d};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver with a one-byte holding register and valid/ack.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = C_DEFAULT_CLK_PER_BIT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rxd,
  output logic [C_DATA_W-1:0] rdata,
  output logic                rdata_valid,
  input  logic                rdata_ack,
  output logic                ferr,
  output logic                overrun,
  output logic                busy
);

  localparam int unsigned CNT_W = $clog2(CLK_PER_BIT);
  localparam logic [CNT_W-1:0] C_CNT_HALF = CNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(CLK_PER_BIT - 1);

  logic rxs;

  uart_state_e         state_q,  state_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic [2:0]          idx_q,    idx_d;
  logic [C_DATA_W-1:0] shift_q,  shift_d;
  logic [C_DATA_W-1:0] rdata_q,  rdata_d;
  logic                valid_q,  valid_d;
  logic                ferr_q,   ferr_d;
  logic                ovr_q,    ovr_d;
  logic                busy_q,   busy_d;

  sync_ff #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxs)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    rdata_d = rdata_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = ovr_q;

    if (rdata_ack && valid_q) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rxs) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == C_CNT_HALF) begin
          cnt_d   = '0;
          state_d = rxs ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == C_CNT_FULL) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[C_DATA_W-1:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (cnt_q == C_CNT_FULL) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          // A fresh byte overrides a same-cycle ack, so valid stays set.
          if (rxs) begin
            rdata_d = shift_q;
            valid_d = 1'b1;
            if (valid_q && !rdata_ack) begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign rdata       = rdata_q;
  assign rdata_valid = valid_q;
  assign ferr        = ferr_q;
  assign overrun     = ovr_q;
  assign busy        = busy_q;

endmodule
`default_nettype wire
